// File: rtl/iter_divider32_if.sv
// Request/response bundle for the iterative RV32M divider.
interface iter_divider32_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, op, dividend, divisor, input busy, done, result);
  modport slave  (input start, op, dividend, divisor, output busy, done, result);
endinterface

// File: rtl/iter_divider32.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU: one trial subtract per cycle,
// sign fix-up in a dedicated cycle, one-cycle done strobe.
module iter_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  iter_divider32_if.slave  dif
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, nxt;

  logic [WIDTH-1:0] quo, rem, dvs, result_q;
  logic [CW-1:0]    cnt;
  logic             is_rem, neg_quo, neg_rem;

  // Accept-time decode of the incoming request
  logic             accept, sgn, a_neg, b_neg, div0, ovf, special;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign accept  = dif.start && (state == IDLE || state == DONE);
  assign sgn     = ~dif.op[0];
  assign a_neg   = sgn & dif.dividend[WIDTH-1];
  assign b_neg   = sgn & dif.divisor[WIDTH-1];
  assign abs_a   = a_neg ? -dif.dividend : dif.dividend;
  assign abs_b   = b_neg ? -dif.divisor  : dif.divisor;
  assign div0    = (dif.divisor == '0);
  assign ovf     = sgn && (dif.dividend == MIN_INT) && (dif.divisor == '1);
  assign special = div0 | ovf;

  // One restoring step; the extra MSB of trial is the borrow
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   trial;
  assign rem_sh = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign trial  = {1'b0, rem_sh} - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = special ? FIX : CALC;
      CALC:    if (cnt == CW'(WIDTH-1)) nxt = FIX;
      FIX:     nxt = DONE;
      DONE:    nxt = accept ? (special ? FIX : CALC) : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    dif.busy   = (state == CALC) || (state == FIX);
    dif.done   = (state == DONE);
    dif.result = result_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      result_q <= '0;
      is_rem   <= 1'b0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (accept) begin
      is_rem  <= dif.op[1];
      cnt     <= '0;
      // Special cases skip CALC, so their final values go straight into quo/rem
      neg_quo <= special ? 1'b0 : (a_neg ^ b_neg);
      neg_rem <= special ? 1'b0 : a_neg;
      dvs     <= abs_b;
      if (div0) begin
        quo <= '1;
        rem <= dif.dividend;
      end else if (ovf) begin
        quo <= MIN_INT;
        rem <= '0;
      end else begin
        quo <= abs_a;
        rem <= '0;
      end
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      if (!trial[WIDTH]) begin
        rem <= trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= rem_sh;
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end else if (state == FIX) begin
      if (is_rem) result_q <= neg_rem ? -rem : rem;
      else        result_q <= neg_quo ? -quo : quo;
    end
  end
endmodule

// File: tb/tb_iter_divider32.sv
// Directed-vector and sequence bench for iter_divider32 (results, latency, reset, back-to-back).
module tb_iter_divider32;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  iter_divider32_if #(.WIDTH(32)) dif ();
  iter_divider32 #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .dif(dif));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  // Issue one op, scramble inputs after accept, wait for done (bounded)
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    dif.start = 1'b1; dif.op = op; dif.dividend = a; dif.divisor = b;
    @(posedge clk);
    @(negedge clk);
    dif.start = 1'b0; dif.dividend = ~a; dif.divisor = ~b; dif.op = ~op;
    lat = 1;
    while (!dif.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = dif.result;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (dif.busy && dif.done) begin
        errors++;
        $display("FAIL busy_done_exclusive: busy=%b done=%b expected not both", dif.busy, dif.done);
      end
    end
  end

  initial begin
    logic [31:0] res;
    int lat, n;
    logic saw;
    logic [1:0] rop;
    logic [31:0] ra, rb;

    vt[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         34};
    vt[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          34};
    vt[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
    vt[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
    vt[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          34};
    vt[5]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  2};
    vt[6]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  2};
    vt[7]  = '{2'b10, 32'h1234,       32'd0,          32'h1234,       2};
    vt[8]  = '{2'b11, 32'h1234,       32'd0,          32'h1234,       2};
    vt[9]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2};
    vt[10] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          2};
    vt[11] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          34};
    vt[12] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
    vt[13] = '{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  34};
    vt[14] = '{2'b10, 32'hFFFF_FFF8,  32'd3,          32'hFFFF_FFFE,  34};
    vt[15] = '{2'b00, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          34};
    vt[16] = '{2'b01, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          34};
    vt[17] = '{2'b11, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  34};

    rst_n = 1'b0;
    dif.start = 1'b0; dif.op = 2'b00; dif.dividend = '0; dif.divisor = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'b0, dif.busy},  32'd0);
    check("reset_done",   {31'b0, dif.done},  32'd0);
    check("reset_result", dif.result,         32'd0);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vt[i].exp);
      check($sformatf("vec%0d_latency", i), lat, vt[i].lat);
    end

    // start held high: ignored during CALC, re-accepted in DONE with the inputs present then
    @(negedge clk);
    dif.start = 1'b1; dif.op = 2'b01; dif.dividend = 32'd100; dif.divisor = 32'd7;
    @(posedge clk);
    @(negedge clk);
    dif.op = 2'b11; dif.dividend = 32'd1000; dif.divisor = 32'd9;
    n = 1;
    while (!dif.done && n < 100) begin
      if (n == 10) check("held_start_busy", {31'b0, dif.busy}, 32'd1);
      @(negedge clk);
      n++;
    end
    check("b2b_first_latency", n, 34);
    check("b2b_first_result", dif.result, 32'd14);
    @(negedge clk);
    dif.start = 1'b0;
    n = 1;
    while (!dif.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    // Gap measured done cycle to done cycle
    check("b2b_gap", n, 34);
    check("b2b_second_result", dif.result, 32'd1);
    repeat (3) @(negedge clk);
    check("result_held", dif.result, 32'd1);
    check("idle_busy", {31'b0, dif.busy}, 32'd0);

    // Reset in the middle of CALC abandons the op
    @(negedge clk);
    dif.start = 1'b1; dif.op = 2'b00; dif.dividend = 32'd1000; dif.divisor = 32'd3;
    @(posedge clk);
    @(negedge clk);
    dif.start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset_busy", {31'b0, dif.busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_busy",   {31'b0, dif.busy}, 32'd0);
    check("midreset_done",   {31'b0, dif.done}, 32'd0);
    check("midreset_result", dif.result,        32'd0);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (dif.done) saw = 1'b1;
    end
    check("no_done_after_reset", {31'b0, saw}, 32'd0);
    run_op(2'b00, 32'hFFFF_FC18, 32'd7, res, lat);
    check("post_reset_result", res, 32'hFFFF_FF72);
    check("post_reset_latency", lat, 34);

    // Random sweep against the arithmetic reference
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case (i % 3)
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if (i % 5 == 4) ra = -32'($urandom_range(1, 1000));
      run_op(rop, ra, rb, res, lat);
      check($sformatf("rand%0d op=%0d a=%h b=%h", i, rop, ra, rb), res, ref_div(rop, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
